// File: rtl/jesd204_latency_pkg.sv
// Shared types and helpers for the JESD204 lane latency/skew monitor.
// Optional statistics are built only with JESD204_LATENCY_SKEW_STATS_EN.
package jesd204_latency_pkg;

  typedef enum logic [1:0] {
    ST_MEASURE,
    ST_SCAN,
    ST_DONE,
    ST_TIMEOUT
  } mon_state_e;

  function automatic int dpw_log2(input int dpw);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == dpw) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/jesd204_latency_minmax_scan.sv
// Walks lane indices 0..NUM_LANES-1, one per cycle, tracking min and max.
// Instantiated only when JESD204_LATENCY_SKEW_STATS_EN is defined.
module jesd204_latency_minmax_scan
  import jesd204_latency_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int VAL_W     = 14,
  parameter int IDX_W     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic [IDX_W-1:0] index_o,
  input  logic [VAL_W-1:0] value_i,
  output logic [VAL_W-1:0] min_o,
  output logic [VAL_W-1:0] max_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LANES - 1);

  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] min_q, min_d;
  logic [VAL_W-1:0] max_q, max_d;
  logic             last;

  assign last = busy_q && (idx_q == LAST);

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    min_d  = min_q;
    max_d  = max_q;
    if (start_i) begin
      busy_d = 1'b1;
      idx_d  = '0;
      min_d  = '0;
      max_d  = '0;
    end else if (busy_q) begin
      // First visited lane seeds both extremes.
      if (idx_q == '0 || value_i < min_q) min_d = value_i;
      if (idx_q == '0 || value_i > max_q) max_d = value_i;
      if (last) begin
        busy_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      min_q  <= '0;
      max_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  assign index_o = idx_q;
  assign min_o   = min_q;
  assign max_o   = max_q;
  assign done_o  = last;

endmodule

// File: rtl/jesd204_lane_latency_skew_monitor.sv
// Per-lane link latency capture, timeout detection and skew statistics.
// Min/max/skew scan is built only with JESD204_LATENCY_SKEW_STATS_EN.
module jesd204_lane_latency_skew_monitor
  import jesd204_latency_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int LATENCY_WIDTH   = 14,
  parameter int MAX_SKEW        = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rearm,
  input  logic [NUM_LANES-1:0]               lane_ready,
  input  logic [4*NUM_LANES-1:0]             lane_frame_align,
  output logic [LATENCY_WIDTH*NUM_LANES-1:0] lane_latency,
  output logic [NUM_LANES-1:0]               lane_latency_ready,
  output logic [LATENCY_WIDTH-1:0]           min_latency,
  output logic [LATENCY_WIDTH-1:0]           max_latency,
  output logic [LATENCY_WIDTH-1:0]           skew,
  output logic                               stats_valid,
  output logic                               skew_error,
  output logic                               timeout
);

  localparam int DPW_LOG2       = dpw_log2(DATA_PATH_WIDTH);
  localparam int BEAT_CNT_WIDTH = LATENCY_WIDTH - DPW_LOG2;
  localparam logic [BEAT_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [BEAT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_LANES-1:0]      cap_vld_q, cap_vld_d;
  logic [NUM_LANES-1:0][BEAT_CNT_WIDTH-1:0] cap_cnt_q, cap_cnt_d;
  mon_state_e                state_q, state_d;
  logic                      cnt_sat;
  logic                      all_cap;
  logic                      unused_align;

`ifdef JESD204_LATENCY_SKEW_STATS_EN
  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                     scan_start;
  logic                     scan_done;
  logic [IDX_W-1:0]         scan_idx;
  logic [LATENCY_WIDTH-1:0] scan_val;
  logic [LATENCY_WIDTH-1:0] scan_min;
  logic [LATENCY_WIDTH-1:0] scan_max;
`endif

  assign cnt_sat      = (cnt_q == CNT_MAX);
  assign unused_align = ^lane_frame_align;

  // Capture state follows lane_ready only until each lane is latched.
  always_comb begin
    cnt_d     = cnt_sat ? cnt_q : cnt_q + BEAT_CNT_WIDTH'(1);
    cap_vld_d = cap_vld_q;
    cap_cnt_d = cap_cnt_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_ready[i] && !cap_vld_q[i]) begin
        cap_vld_d[i] = 1'b1;
        cap_cnt_d[i] = cnt_q;
      end
    end
    if (rearm) begin
      cnt_d     = '0;
      cap_vld_d = '0;
    end
  end

  assign all_cap = &cap_vld_d;

  always_comb begin
    state_d = state_q;
`ifdef JESD204_LATENCY_SKEW_STATS_EN
    scan_start = 1'b0;
`endif
    unique case (state_q)
      ST_MEASURE: begin
        if (all_cap) begin
`ifdef JESD204_LATENCY_SKEW_STATS_EN
          state_d    = ST_SCAN;
          scan_start = 1'b1;
`else
          state_d    = ST_DONE;
`endif
        end else if (cnt_sat) begin
          state_d = ST_TIMEOUT;
        end
      end
`ifdef JESD204_LATENCY_SKEW_STATS_EN
      ST_SCAN: begin
        if (scan_done) state_d = ST_DONE;
      end
`endif
      default: ;
    endcase
    if (rearm) begin
      state_d = ST_MEASURE;
`ifdef JESD204_LATENCY_SKEW_STATS_EN
      scan_start = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      cap_vld_q <= '0;
      cap_cnt_q <= '0;
      state_q   <= ST_MEASURE;
    end else begin
      cnt_q     <= cnt_d;
      cap_vld_q <= cap_vld_d;
      cap_cnt_q <= cap_cnt_d;
      state_q   <= state_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_latency[g*LATENCY_WIDTH +: LATENCY_WIDTH] =
      {cap_cnt_q[g], lane_frame_align[4*g +: DPW_LOG2]};
  end

  assign lane_latency_ready = cap_vld_q;
  assign stats_valid        = (state_q == ST_DONE);
  assign timeout            = (state_q == ST_TIMEOUT);

`ifdef JESD204_LATENCY_SKEW_STATS_EN
  assign scan_val =
    lane_latency[int'(scan_idx)*LATENCY_WIDTH +: LATENCY_WIDTH];

  // Rearm also restarts the scanner so a stale scan cannot leak through.
  jesd204_latency_minmax_scan #(
    .NUM_LANES (NUM_LANES),
    .VAL_W     (LATENCY_WIDTH),
    .IDX_W     (IDX_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset | rearm),
    .start_i (scan_start),
    .index_o (scan_idx),
    .value_i (scan_val),
    .min_o   (scan_min),
    .max_o   (scan_max),
    .done_o  (scan_done)
  );

  assign min_latency = scan_min;
  assign max_latency = scan_max;
  assign skew        = scan_max - scan_min;
  assign skew_error  = stats_valid &&
                       (skew > LATENCY_WIDTH'(MAX_SKEW));
`else
  assign min_latency = '0;
  assign max_latency = '0;
  assign skew        = '0;
  assign skew_error  = 1'b0;
`endif

endmodule

// File: tb/tb_jesd204_lane_latency_skew_monitor.sv
// Self-checking bench for jesd204_lane_latency_skew_monitor (4 lanes, DPW 4).
// Expectations follow JESD204_LATENCY_SKEW_STATS_EN when it is defined.
module tb_jesd204_lane_latency_skew_monitor;

  localparam int NL    = 4;
  localparam int DPW   = 4;
  localparam int LW    = 14;
  localparam int MS    = 16;
  localparam int SATC  = 4095;
  localparam int NEVER = 8191;
`ifdef JESD204_LATENCY_SKEW_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             rearm;
  logic [NL-1:0]    lane_ready;
  logic [4*NL-1:0]  lane_frame_align;
  logic [LW*NL-1:0] lane_latency;
  logic [NL-1:0]    lane_latency_ready;
  logic [LW-1:0]    min_latency;
  logic [LW-1:0]    max_latency;
  logic [LW-1:0]    skew;
  logic             stats_valid;
  logic             skew_error;
  logic             timeout;

  always #5 clk = ~clk;

  jesd204_lane_latency_skew_monitor #(
    .NUM_LANES       (NL),
    .DATA_PATH_WIDTH (DPW),
    .LATENCY_WIDTH   (LW),
    .MAX_SKEW        (MS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .rearm              (rearm),
    .lane_ready         (lane_ready),
    .lane_frame_align   (lane_frame_align),
    .lane_latency       (lane_latency),
    .lane_latency_ready (lane_latency_ready),
    .min_latency        (min_latency),
    .max_latency        (max_latency),
    .skew               (skew),
    .stats_valid        (stats_valid),
    .skew_error         (skew_error),
    .timeout            (timeout)
  );

  typedef struct packed {
    logic [NL-1:0][12:0] rdy;
    logic [NL-1:0][3:0]  align;
  } vec_t;

  typedef struct packed {
    logic [NL-1:0][LW-1:0] lat;
    logic [LW-1:0]         mn;
    logic [LW-1:0]         mx;
    logic [LW-1:0]         sk;
    logic                  err;
    logic                  to;
    logic [NL-1:0]         rmask;
    logic [31:0]           cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  function automatic vec_t mk(input int r0, r1, r2, r3,
                              input int a0, a1, a2, a3);
    vec_t v;
    v.rdy   = {13'(r3), 13'(r2), 13'(r1), 13'(r0)};
    v.align = {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    int   mn, mx, last, l;
    bit   all;
    e    = '0;
    mn   = 1 << LW;
    mx   = 0;
    last = 0;
    all  = 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (int'(v.rdy[i]) <= SATC) begin
        l          = int'(v.rdy[i]) * DPW + int'(v.align[i]);
        e.rmask[i] = 1'b1;
        e.lat[i]   = LW'(l);
        if (l < mn) mn = l;
        if (l > mx) mx = l;
        if (int'(v.rdy[i]) > last) last = int'(v.rdy[i]);
      end else begin
        all      = 1'b0;
        e.lat[i] = LW'(v.align[i]);
      end
    end
    if (all) begin
      e.cyc = 32'(last + 1 + (STATS ? NL : 0));
      if (STATS) begin
        e.mn  = LW'(mn);
        e.mx  = LW'(mx);
        e.sk  = LW'(mx - mn);
        e.err = (mx - mn) > MS;
      end
    end else begin
      e.to  = 1'b1;
      e.cyc = 32'(SATC + 1);
    end
    return e;
  endfunction

  task automatic do_reset();
    reset      = 1'b1;
    rearm      = 1'b0;
    lane_ready = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic cmp_done(input string tag, input exp_t e, input int cyc);
    chk({tag, " cycle"}, 32'(cyc), e.cyc);
    chk({tag, " timeout"}, 32'(timeout), 32'(e.to));
    chk({tag, " stats_valid"}, 32'(stats_valid), 32'(!e.to));
    chk({tag, " ready"}, 32'(lane_latency_ready), 32'(e.rmask));
    for (int i = 0; i < NL; i++)
      chk($sformatf("%s lat%0d", tag, i),
          32'(lane_latency[i*LW +: LW]), 32'(e.lat[i]));
    chk({tag, " min"}, 32'(min_latency), 32'(e.mn));
    chk({tag, " max"}, 32'(max_latency), 32'(e.mx));
    chk({tag, " skew"}, 32'(skew), 32'(e.sk));
    chk({tag, " skew_error"}, 32'(skew_error), 32'(e.err));
  endtask

  // Ends sampling at the negedge of the first DONE/TIMEOUT cycle.
  task automatic run_vec(input int k, input vec_t v, output exp_t e);
    int c;
    bit seen;
    do_reset();
    lane_frame_align = v.align;
    sb.push_back(model(v));
    c    = 0;
    seen = 1'b0;
    while (!seen && c < 5000) begin
      for (int i = 0; i < NL; i++) lane_ready[i] = (c >= int'(v.rdy[i]));
      @(negedge clk);
      if (stats_valid || timeout) begin
        seen = 1'b1;
        e    = sb.pop_front();
        cmp_done($sformatf("v%0d", k), e, c);
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (!seen) begin
      e = sb.pop_front();
      chk($sformatf("v%0d completion", k), 32'(0), 32'(1));
    end
  endtask

  initial begin
    exp_t e, g;
    int   k;
    bit   seen;

    vecs[0] = mk(10, 12, 15, 20, 0, 0, 0, 0);
    vecs[1] = mk(5, 5, 5, 5, 3, 1, 0, 2);
    vecs[2] = mk(0, 0, 0, 0, 1, 2, 3, 0);
    vecs[3] = mk(2, 2, 2, 6, 0, 0, 0, 0);
    vecs[4] = mk(2, 2, 2, 6, 0, 0, 0, 1);
    vecs[5] = mk(30, 3, 17, 9, 2, 3, 1, 0);
    vecs[6] = mk(0, 100, 4000, SATC, 0, 0, 0, 3);
    vecs[7] = mk(0, 1, 2, NEVER, 0, 0, 0, 0);

    // Reset overrides a simultaneous rearm and lane_ready.
    reset            = 1'b1;
    rearm            = 1'b1;
    lane_ready       = '1;
    lane_frame_align = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst lane_latency", 32'(lane_latency != '0), 32'(0));
    chk("rst ready", 32'(lane_latency_ready), 32'(0));
    chk("rst stats_valid", 32'(stats_valid), 32'(0));
    chk("rst timeout", 32'(timeout), 32'(0));
    chk("rst skew_error", 32'(skew_error), 32'(0));
    chk("rst min", 32'(min_latency), 32'(0));
    chk("rst max", 32'(max_latency), 32'(0));
    chk("rst skew", 32'(skew), 32'(0));

    for (int v = 0; v < 8; v++) begin
      run_vec(v, vecs[v], e);
      if (v == 0) begin
        // Toggling lane_ready after capture must not disturb results.
        @(posedge clk); #1;
        lane_ready = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        lane_ready = '1;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < NL; i++)
          chk($sformatf("toggle lat%0d", i),
              32'(lane_latency[i*LW +: LW]), 32'(e.lat[i]));
        chk("toggle stats_valid", 32'(stats_valid), 32'(1));

        // Rearm in DONE with lane_ready held high.
        @(posedge clk); #1;
        rearm = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0;
        @(negedge clk);
        chk("rearm ready clr", 32'(lane_latency_ready), 32'(0));
        chk("rearm stats clr", 32'(stats_valid), 32'(0));
        g       = '0;
        g.rmask = '1;
        g.cyc   = 32'(STATS ? NL : 0);
        sb.push_back(g);
        @(posedge clk); #1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
          @(negedge clk);
          if (stats_valid) begin
            seen = 1'b1;
            cmp_done("rearm", sb.pop_front(), k);
          end else begin
            @(posedge clk); #1;
            k++;
          end
        end
        if (!seen) begin
          g = sb.pop_front();
          chk("rearm completion", 32'(0), 32'(1));
        end
      end
    end

    // Ready during the rearm cycle is ignored, then captures count 0.
    do_reset();
    lane_frame_align = '0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rearm      = 1'b1;
    lane_ready = 4'b0001;
    @(posedge clk); #1;
    rearm = 1'b0;
    @(negedge clk);
    chk("rearm-meas no cap", 32'(lane_latency_ready), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rearm-meas cap", 32'(lane_latency_ready), 32'(1));
    chk("rearm-meas lat0", 32'(lane_latency[0 +: LW]), 32'(0));
    chk("rearm-meas timeout", 32'(timeout), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jesd204_lane_latency_skew_monitor.md
JESD204_LANE_LATENCY_SKEW_MONITOR -- requirements
Module: jesd204_lane_latency_skew_monitor

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1, lane count (1..32).
REQ-002 SHALL have parameter DATA_PATH_WIDTH, default 4, octets per beat (2, 4, 8 or 16); DPW_LOG2 = log2(DATA_PATH_WIDTH).
REQ-003 SHALL have parameter LATENCY_WIDTH, default 14, octet-resolution latency width; BEAT_CNT_WIDTH = LATENCY_WIDTH-DPW_LOG2.
REQ-004 SHALL have parameter MAX_SKEW, default 16, permitted skew in octets.
REQ-005 SHALL have ports clk in 1 (clock) and reset in 1; reset is synchronous, active-high.
REQ-006 SHALL have port rearm, in, 1, single-cycle restart of the measurement.
REQ-007 SHALL have port lane_ready, in, NUM_LANES, per-lane link-ready.
REQ-008 SHALL have port lane_frame_align, in, 4*NUM_LANES, per-lane octet offset; bits [DPW_LOG2-1:0] of each nibble are used.
REQ-009 SHALL have port lane_latency, out, LATENCY_WIDTH*NUM_LANES, per-lane latency in octets.
REQ-010 SHALL have port lane_latency_ready, out, NUM_LANES, per-lane capture flag.
REQ-011 SHALL have ports min_latency and max_latency, out, LATENCY_WIDTH each, plus skew, out, LATENCY_WIDTH.
REQ-012 SHALL have ports stats_valid, skew_error and timeout, out, 1 each.

Function
REQ-013 Beat counter SHALL clear on reset or rearm, otherwise increment by 1 per cycle and saturate at all-ones (no wrap).
REQ-014 Lane i SHALL capture the current counter value in the first cycle lane_ready[i]=1 while uncaptured; later lane_ready changes SHALL be ignored.
REQ-015 lane_latency[i] SHALL be {captured_count, lane_frame_align[4i+DPW_LOG2-1:4i]}, concatenated live, not latched.
REQ-016 A lane readying in the saturation cycle SHALL capture the all-ones count.
REQ-017 FSM states: MEASURE, SCAN, DONE, TIMEOUT; reset/rearm enter MEASURE from any state.
REQ-018 MEASURE->SCAN when all lanes captured; MEASURE->TIMEOUT when counter saturated with any lane uncaptured; all-captured takes priority in the same cycle.
REQ-019 SCAN SHALL visit one lane per cycle, index 0..NUM_LANES-1, tracking min and max of lane_latency, then enter DONE (NUM_LANES cycles in SCAN).
REQ-020 In DONE: stats_valid=1; skew=max_latency-min_latency (unsigned, never negative); skew_error=1 iff skew>MAX_SKEW.
REQ-021 In TIMEOUT: timeout=1, stats_valid=0, skew_error=0; captured lanes keep their values.
REQ-022 rearm SHALL take effect next cycle; a lane_ready high during the rearm cycle SHALL NOT capture, and it captures count 0 in the following cycle.
REQ-023 With NUM_LANES=1, min=max=lane_latency[0] and skew=0.

Reset
REQ-024 Reset SHALL set counter 0, all captures and lane_latency_ready 0, state MEASURE, min/max/skew 0, stats_valid/skew_error/timeout 0.
REQ-025 Reset SHALL override rearm and lane_ready in the same cycle.

Configuration
REQ-026 Macro JESD204_LATENCY_SKEW_STATS_EN defined: SCAN, min/max/skew, stats_valid and skew_error SHALL be implemented as above.
REQ-027 Macro undefined: MEASURE->DONE directly, min_latency/max_latency/skew/skew_error SHALL be tied 0, stats_valid SHALL be 1 in DONE; capture and timeout unchanged.

Structure
REQ-028 Package jesd204_latency_pkg SHALL hold the FSM state enum and the DPW_LOG2 helper function.
REQ-029 Min/max scan SHALL be a sub-module jesd204_latency_minmax_scan (start, index output, value input, min/max/done outputs).

Verification
REQ-030 DPW=4, 4 lanes, lane_ready rising at cycles 10, 12, 15, 20 after reset, align 0 -> latencies 40, 48, 60, 80; stats_valid 4 cycles after last capture; skew=40, skew_error=1.
REQ-031 Same with lane_frame_align={3,1,0,2} and ready all at cycle 5 -> latencies 23, 21, 20, 22; min 20, max 23, skew 3, skew_error 0.
REQ-032 Lane 3 never ready -> counter saturates at 4095; timeout=1 cycle after saturation; lane_latency_ready=4'b0111.
REQ-033 rearm pulse in DONE with lane_ready held high -> lane_latency_ready clears for one cycle, then all lanes capture count 0; new stats_valid 4 cycles later.
REQ-034 lane_ready toggled low/high after capture -> lane_latency unchanged; reset asserted together with rearm -> all outputs at reset values.
